// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and default width.
package serial_adder_pkg;

  localparam int unsigned SA_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder_rtl.sv
// 1-bit full-adder cell; the single combinational bit-slice of serial_adder.
module full_adder_rtl (
  input  logic a,
  input  logic b,
  input  logic carry,
  output logic sum,
  output logic carryout
);

  assign sum      = a ^ b ^ carry;
  assign carryout = (a & b) | (carry & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell, carry held in a flop.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last;

  full_adder_rtl u_fa (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .carry    (carry),
    .sum      (fa_s),
    .carryout (fa_c)
  );

  assign r_next = {fa_s, r_sh[WIDTH-1:1]};
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  // Outputs load from the shift/carry next-values so they land on the same edge as DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= r_next;
            cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB during the final RUN cycle
            ovf   <= carry ^ fa_c;
`endif
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [W-1:0] exp_sum_q  = '0;
  logic         exp_cout_q = 1'b0;
  logic         exp_ovf_q  = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact unsigned sum, signed overflow from signed interpretation.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    longint unsigned t;
    longint sa, sb, ss;
    t  = longint'(ta) + longint'(tb) + longint'(tc);
    exp_sum_q  = t[W-1:0];
    exp_cout_q = t[W];
    sa = ta[W-1] ? longint'(ta) - (64'sd1 <<< W) : longint'(ta);
    sb = tb[W-1] ? longint'(tb) - (64'sd1 <<< W) : longint'(tb);
    ss = sa + sb + longint'(tc);
    exp_ovf_q = (ss > (64'sd1 <<< (W-1)) - 1) || (ss < -(64'sd1 <<< (W-1)));
  endtask

  task automatic check_result(input string tag);
    check({tag, "_sum"}, sum, exp_sum_q);
    check({tag, "_cout"}, cout, exp_cout_q);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, exp_ovf_q);
`endif
  endtask

  // inj >= 0: pulse start with a junk operand during that RUN cycle index.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int inj, input string tag);
    int  i;
    bit  seen;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    seen = 1'b0;
    for (i = 0; i < int'(W) + 4; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({tag, "_busy_run"}, busy, 1);
      check({tag, "_sum_hold"}, sum, exp_sum_q);
      if (inj >= 0 && i == inj) begin
        start = 1'b1; a = 8'hAA; b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, i, W);
    check({tag, "_busy_at_done"}, busy, 0);
    model(ta, tb, tc);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    bit extra;
    int npulse;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, -1, "t1");
    run_op(8'hFF, 8'h01, 1'b0, -1, "t2a");
    run_op(8'hFF, 8'hFF, 1'b1, -1, "t2b");

    run_op(8'h10, 8'h20, 1'b0, 2, "t3");
    extra = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (done || busy) extra = 1'b1;
      @(negedge clk);
    end
    check("t3_start_ignored", extra, 0);

    // Reset in RUN cycle 4 of 0F+01.
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t4_busy_rst", busy, 0);
    check("t4_done_rst", done, 0);
    check("t4_sum_rst", sum, 0);
    check("t4_cout_rst", cout, 0);
    exp_sum_q = '0; exp_cout_q = 1'b0; exp_ovf_q = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    extra = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) extra = 1'b1;
      @(negedge clk);
    end
    check("t4_no_done", extra, 0);
    run_op(8'h01, 8'h01, 1'b0, -1, "t4b");

    // start held high: a new op every WIDTH+2 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    npulse = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        check("t5_pulse_pos", c, 8 + 10 * npulse);
        check("t5_sum", sum, 8'h02);
        npulse++;
      end
    end
    check("t5_pulses", npulse, 3);
    start = 1'b0;
    extra = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (!busy && !done) begin
        extra = 1'b0;
        break;
      end
    end
    check("t5_drain", extra, 0);
    model(8'h01, 8'h01, 1'b0);

    run_op(8'h7F, 8'h01, 1'b0, -1, "t6a");
    run_op(8'hFF, 8'h01, 1'b0, -1, "t6b");
    run_op(8'h80, 8'h80, 1'b0, -1, "t6c");
    run_op(8'h00, 8'h00, 1'b0, -1, "t6d");

    for (int r = 0; r < 40; r++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), -1, "rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell.
- Operands are captured on start and fed LSB-first through the cell, one bit per clock; the carry is held in a flop between bits.
- Result is presented with a one-cycle done pulse.
- Serves as the sequential datapath stage that drives the full-adder cell, for area-constrained accumulate paths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while an addition is in progress (state RUN).
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry flop and bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge k, load a, b into shift registers, cin into carry flop, counter=0; go RUN.
- RUN:
  - Each cycle, the cell takes bit0 of A-shift, bit0 of B-shift and the carry flop.
  - The cell's sum bit is shifted into the MSB of the result shift register; the carry flop takes the cell's carry.
  - Operands shift right; counter increments.
  - After WIDTH RUN cycles (edge k+WIDTH), go DONE.
- On entry to DONE (edge k+WIDTH): sum <= result shift register, cout <= carry flop.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH. With WIDTH=8, done is seen 8 cycles after the start edge.
- busy=1 exactly in RUN, i.e. for WIDTH cycles.
- sum/cout change only on entry to DONE; they hold until the next completed operation. They stay stable during RUN.
- start in RUN or DONE: ignored, not queued. start held high continuously: a new operation begins from IDLE one cycle after done.
- Arithmetic: unsigned; {cout,sum} = a + b + cin, exact, with no truncation.
- Counter width: $clog2(WIDTH)+1, so the count of WIDTH is representable.
- Reset mid-operation: immediate abort; all outputs return to reset values, with no done pulse.
- Inputs a, b, cin are don't-care outside the accepting cycle.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (output, 1), registered alongside sum.
  - ovf = (carry into MSB) XOR (carry out of MSB), i.e. two's-complement signed overflow.
  - Carry into MSB is the carry flop value captured at the final RUN cycle input.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package/include serial_adder_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant SA_WIDTH_DEF=8.
- One sub-module: instantiate the existing full_adder_rtl cell (A, B, carry -> sum, carryout) as the sole combinational bit-slice.
- All sequencing stays in serial_adder.

Test Plan:
- 1. a=8'h05, b=8'h03, cin=0, start pulse -> busy high 8 cycles; done pulse 8 cycles after start edge; sum=8'h08, cout=0.
- 2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- 3. Start 8'h10+8'h20, then pulse start with a=8'hAA at RUN cycle 3 -> ignored; sum=8'h30; exactly one done pulse.
- 4. Assert rst_n=0 at RUN cycle 4 of 8'h0F+8'h01 -> busy, done, sum and cout go to 0 asynchronously; no done pulse; next start 8'h01+8'h01 yields sum=8'h02.
- 5. start held high for 30 cycles with a=8'h01, b=8'h01 -> done pulses every 10 cycles (8 RUN + DONE + IDLE); sum=8'h02 each time.
- 6. With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> sum=8'h80, ovf=1; 8'hFF+8'h01 -> sum=8'h00, cout=1, ovf=0.
